// File: rtl/sprite_pkg.sv
// Shared types, default geometry and helpers for the sprite command receiver.
package sprite_pkg;

    localparam int CANVAS_WIDTH_DEF  = 360;
    localparam int CANVAS_HEIGHT_DEF = 720;
    localparam int NUM_FRAMES_DEF    = 5;
    localparam int MAX_SPRITES_DEF   = 64;

    localparam int XW_DEF = $clog2(CANVAS_WIDTH_DEF);
    localparam int YW_DEF = $clog2(CANVAS_HEIGHT_DEF);
    localparam int FW_DEF = $clog2(NUM_FRAMES_DEF);

    // One stored sprite command; the RAM word uses this field order (x in the MSBs).
    typedef struct packed {
        logic [XW_DEF-1:0] x;
        logic [YW_DEF-1:0] y;
        logic [FW_DEF-1:0] frame;
    } sprite_cmd_t;

    typedef enum logic {
        RX_RECEIVE = 1'b0,
        RX_FULL    = 1'b1
    } rx_state_t;

    // True when a coordinate/frame value lies inside its legal range.
    function automatic logic in_range(input int unsigned value, input int unsigned limit);
        return value < limit;
    endfunction

endpackage

// File: rtl/sprite_list_ram.sv
// Simple dual-port RAM holding both sprite banks: one synchronous write port and
// one registered read port, shaped so it maps onto a single block RAM.
module sprite_list_ram
    import sprite_pkg::*;
#(
    parameter int DEPTH = 2 * MAX_SPRITES_DEF,
    parameter int DW    = $bits(sprite_cmd_t),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port: store the accepted command.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered output, returns contents as they were before this edge.
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_list_rx.sv
// Sprite command receiver: double-buffered sprite list. Commands are written into
// the write bank during a video frame; new_frame swaps banks and the renderer reads
// the display bank through a one-cycle registered port.
// Optional feature: define SPRITE_RX_BOUNDS_CHECK_EN to drop (but still handshake)
// commands whose x, y or frame fall outside the canvas / animation range.
module sprite_list_rx
    import sprite_pkg::*;
#(
    parameter int CANVAS_WIDTH  = CANVAS_WIDTH_DEF,
    parameter int CANVAS_HEIGHT = CANVAS_HEIGHT_DEF,
    parameter int NUM_FRAMES    = NUM_FRAMES_DEF,
    parameter int MAX_SPRITES   = MAX_SPRITES_DEF,
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT),
    localparam int FW = $clog2(NUM_FRAMES),
    localparam int IW = $clog2(MAX_SPRITES)
) (
    input  logic          clk_pixel,
    input  logic          sys_rst_n,
    input  logic          new_frame,
    input  logic          sprite_valid,
    input  logic [XW-1:0] sprite_x,
    input  logic [YW-1:0] sprite_y,
    input  logic [FW-1:0] sprite_frame,
    output logic          sprite_ready,
    input  logic [IW-1:0] rd_index,
    output logic          rd_valid,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic [FW-1:0] rd_frame,
    output logic [IW:0]   sprite_count,
    output logic          overflow
);

    localparam int DW = XW + YW + FW;
    localparam logic [IW:0] FULL_COUNT = (IW+1)'(MAX_SPRITES);

    rx_state_t   state_q, state_d;
    logic        wr_bank_q, wr_bank_d;
    logic [IW:0] wr_count_q, wr_count_d;
    logic [IW:0] sprite_count_q, sprite_count_d;
    logic        overflow_q, overflow_d;
    logic        ovf_pending_q, ovf_pending_d;
    logic        rd_valid_q;

    logic          ready;
    logic          xfer;
    logic          store;
    logic [DW-1:0] ram_rdata;

    assign xfer = sprite_valid && sprite_ready;

`ifdef SPRITE_RX_BOUNDS_CHECK_EN
    assign store = xfer
                && in_range(32'(sprite_x), CANVAS_WIDTH)
                && in_range(32'(sprite_y), CANVAS_HEIGHT)
                && in_range(32'(sprite_frame), NUM_FRAMES);
`else
    assign store = xfer;
`endif

    // Next-state and handshake logic; new_frame overrides everything else.
    always_comb begin
        state_d        = state_q;
        wr_bank_d      = wr_bank_q;
        wr_count_d     = wr_count_q;
        sprite_count_d = sprite_count_q;
        overflow_d     = overflow_q;
        ovf_pending_d  = ovf_pending_q;
        ready          = 1'b0;

        case (state_q)
            RX_RECEIVE: ready = !new_frame;
            RX_FULL:    ready = 1'b0;
            default:    ready = 1'b0;
        endcase

        if (new_frame) begin
            state_d        = RX_RECEIVE;
            wr_bank_d      = !wr_bank_q;
            sprite_count_d = wr_count_q;
            wr_count_d     = '0;
            overflow_d     = ovf_pending_q;
            ovf_pending_d  = 1'b0;
        end else begin
            if (sprite_valid && state_q == RX_FULL) begin
                ovf_pending_d = 1'b1;
            end
            if (store) begin
                wr_count_d = wr_count_q + 1'b1;
                if (wr_count_d == FULL_COUNT) begin
                    state_d = RX_FULL;
                end
            end
        end
    end

    // Ready is held low while reset is asserted.
    assign sprite_ready = ready && sys_rst_n;

    // Control state, counters and bank select.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= RX_RECEIVE;
            wr_bank_q      <= 1'b0;
            wr_count_q     <= '0;
            sprite_count_q <= '0;
            overflow_q     <= 1'b0;
            ovf_pending_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_bank_q      <= wr_bank_d;
            wr_count_q     <= wr_count_d;
            sprite_count_q <= sprite_count_d;
            overflow_q     <= overflow_d;
            ovf_pending_q  <= ovf_pending_d;
        end
    end

    // Read-valid pipeline, aligned with the RAM's registered output.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ({1'b0, rd_index} < sprite_count_q);
        end
    end

    // Both banks share one RAM; the bank bit is the address MSB. The reader always
    // addresses the bank opposite to the one being written, so no collision occurs.
    sprite_list_ram #(
        .DEPTH (2 * MAX_SPRITES),
        .DW    (DW)
    ) u_ram (
        .clk_i   (clk_pixel),
        .we_i    (store),
        .waddr_i ({wr_bank_q, wr_count_q[IW-1:0]}),
        .wdata_i ({sprite_x, sprite_y, sprite_frame}),
        .raddr_i ({!wr_bank_q, rd_index}),
        .rdata_o (ram_rdata)
    );

    assign rd_valid     = rd_valid_q;
    assign rd_x         = rd_valid_q ? ram_rdata[DW-1 -: XW]    : '0;
    assign rd_y         = rd_valid_q ? ram_rdata[FW +: YW]      : '0;
    assign rd_frame     = rd_valid_q ? ram_rdata[FW-1:0]        : '0;
    assign sprite_count = sprite_count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_sprite_list_rx.sv
// Directed self-checking bench for sprite_list_rx: swap/readback, full bank and
// overflow, valid coincident with new_frame, read sweep across a swap, reset
// mid-frame and out-of-range commands.
module tb_sprite_list_rx;

    logic       clk_pixel = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       new_frame = 1'b0;
    logic       sprite_valid = 1'b0;
    logic [8:0] sprite_x = '0;
    logic [9:0] sprite_y = '0;
    logic [2:0] sprite_frame = '0;
    logic       sprite_ready;
    logic [5:0] rd_index = '0;
    logic       rd_valid;
    logic [8:0] rd_x;
    logic [9:0] rd_y;
    logic [2:0] rd_frame;
    logic [6:0] sprite_count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    sprite_list_rx dut (
        .clk_pixel    (clk_pixel),
        .sys_rst_n    (sys_rst_n),
        .new_frame    (new_frame),
        .sprite_valid (sprite_valid),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_frame (sprite_frame),
        .sprite_ready (sprite_ready),
        .rd_index     (rd_index),
        .rd_valid     (rd_valid),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_frame     (rd_frame),
        .sprite_count (sprite_count),
        .overflow     (overflow)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // Present one command and wait (bounded) for it to be accepted.
    task automatic send(input int x, input int y, input int f);
        bit ok = 1'b0;
        logic rdy;
        sprite_valid = 1'b1;
        sprite_x     = 9'(x);
        sprite_y     = 10'(y);
        sprite_frame = 3'(f);
        for (int i = 0; i < 20 && !ok; i++) begin
            #2;
            rdy = sprite_ready;
            @(posedge clk_pixel);
            #1;
            if (rdy) ok = 1'b1;
        end
        sprite_valid = 1'b0;
        $display("send x=%0d y=%0d f=%0d accepted=%0d", x, y, f, ok);
        check("handshake", 32'(ok), 32'd1);
    endtask

    // One-cycle new_frame pulse; ready must be low during it.
    task automatic swap(input string tag);
        new_frame = 1'b1;
        #2;
        check({tag, "_ready_in_swap"}, 32'(sprite_ready), 32'd0);
        @(posedge clk_pixel);
        #1;
        new_frame = 1'b0;
        $display("swap %s count=%0d overflow=%0d", tag, sprite_count, overflow);
    endtask

    // Issue one read index and check the result one cycle later.
    task automatic rd_chk(input string tag, input int idx, input int v,
                          input int x, input int y, input int f);
        rd_index = 6'(idx);
        tick();
        $display("read %s idx=%0d valid=%0d x=%0d y=%0d f=%0d", tag, idx, rd_valid, rd_x, rd_y, rd_frame);
        check({tag, "_valid"}, 32'(rd_valid), 32'(v));
        check({tag, "_x"}, 32'(rd_x), 32'(x));
        check({tag, "_y"}, 32'(rd_y), 32'(y));
        check({tag, "_f"}, 32'(rd_frame), 32'(f));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Read-during-swap vectors: index, then expected valid/x/y/frame.
    int sw_idx [6] = '{0, 1, 0, 1, 2, 3};
    int sw_v   [6] = '{1, 0, 1, 1, 1, 0};
    int sw_x   [6] = '{7, 0, 7, 3, 5, 0};
    int sw_y   [6] = '{8, 0, 8, 4, 6, 0};
    int sw_f   [6] = '{2, 0, 2, 1, 2, 0};

    initial begin
        // ---- reset ----
        sys_rst_n = 1'b0;
        repeat (2) tick();
        check("rst_ready", 32'(sprite_ready), 32'd0);
        check("rst_count", 32'(sprite_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_x", 32'(rd_x), 32'd0);
        sys_rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(sprite_ready), 32'd1);

        // ---- basic swap and readback ----
        send(10, 20, 1);
        send(30, 40, 2);
        send(359, 719, 4);
        check("basic_count_pre", 32'(sprite_count), 32'd0);
        rd_chk("basic_invisible", 0, 0, 0, 0, 0);
        swap("basic");
        check("basic_count", 32'(sprite_count), 32'd3);
        check("basic_ovf", 32'(overflow), 32'd0);
        rd_chk("basic0", 0, 1, 10, 20, 1);
        rd_chk("basic1", 1, 1, 30, 40, 2);
        rd_chk("basic2", 2, 1, 359, 719, 4);
        rd_chk("basic3", 3, 0, 0, 0, 0);

        // ---- full bank ----
        for (int i = 0; i < 64; i++) send(i, 2 * i + 1, i % 5);
        #2;
        check("full_ready_low", 32'(sprite_ready), 32'd0);
        sprite_valid = 1'b1;
        sprite_x = 9'd100;
        sprite_y = 10'd100;
        sprite_frame = 3'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("full_held", 32'(sprite_ready), 32'd0);
        end
        tick();
        swap("full");
        check("full_count", 32'(sprite_count), 32'd64);
        check("full_ovf", 32'(overflow), 32'd1);
        #2;
        check("full_ready_after", 32'(sprite_ready), 32'd1);
        tick();
        sprite_valid = 1'b0;
        rd_chk("full0", 0, 1, 0, 1, 0);
        rd_chk("full63", 63, 1, 63, 127, 3);
        swap("held");
        check("held_count", 32'(sprite_count), 32'd1);
        check("held_ovf", 32'(overflow), 32'd0);
        rd_chk("held0", 0, 1, 100, 100, 3);
        rd_chk("held1", 1, 0, 0, 0, 0);

        // ---- valid coincident with new_frame ----
        sprite_valid = 1'b1;
        sprite_x = 9'd7;
        sprite_y = 10'd8;
        sprite_frame = 3'd2;
        swap("coinc");
        check("coinc_count", 32'(sprite_count), 32'd0);
        #2;
        check("coinc_ready_next", 32'(sprite_ready), 32'd1);
        tick();
        sprite_valid = 1'b0;
        swap("coinc2");
        check("coinc2_count", 32'(sprite_count), 32'd1);

        // ---- read sweep across a swap ----
        send(1, 2, 0);
        send(3, 4, 1);
        send(5, 6, 2);
        for (int c = 0; c < 6; c++) begin
            new_frame = (c == 2);
            rd_chk($sformatf("sweep%0d", c), sw_idx[c], sw_v[c], sw_x[c], sw_y[c], sw_f[c]);
            new_frame = 1'b0;
        end
        check("sweep_count", 32'(sprite_count), 32'd3);

        // ---- reset mid-frame ----
        for (int i = 0; i < 5; i++) send(50 + i, 60 + i, 1);
        sys_rst_n = 1'b0;
        #2;
        check("mrst_ready", 32'(sprite_ready), 32'd0);
        check("mrst_count", 32'(sprite_count), 32'd0);
        check("mrst_rd_valid", 32'(rd_valid), 32'd0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        send(11, 12, 3);
        send(13, 14, 4);
        swap("mrst");
        check("mrst_count_after", 32'(sprite_count), 32'd2);
        rd_chk("mrst0", 0, 1, 11, 12, 3);
        rd_chk("mrst1", 1, 1, 13, 14, 4);
        rd_chk("mrst2", 2, 0, 0, 0, 0);

        // ---- out-of-range commands ----
        send(360, 0, 0);
        send(5, 5, 5);
        swap("bounds");
`ifdef SPRITE_RX_BOUNDS_CHECK_EN
        check("bounds_count", 32'(sprite_count), 32'd0);
        rd_chk("bounds0", 0, 0, 0, 0, 0);
`else
        check("bounds_count", 32'(sprite_count), 32'd2);
        rd_chk("bounds0", 0, 1, 360, 0, 0);
        rd_chk("bounds1", 1, 1, 5, 5, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
